// File: rtl/ps2_pkg.sv
// PS/2 set-2 scan codes, receiver states and note-key indices for the piano keyboard front end.
// Constants and a combinational lookup only: no latency, no flow control.
package ps2_pkg;

   localparam logic [0:0] OCIOSO = 1'b0;
   localparam logic [0:0] RECEBE = 1'b1;

   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BRK      = 8'hF0;
   localparam logic [7:0] SC_ENTER    = 8'h5A;
   localparam logic [7:0] SC_DIREITA  = 8'h74;
   localparam logic [7:0] SC_ESQUERDA = 8'h6B;

   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_W = 8'h1D;
   localparam logic [7:0] SC_S = 8'h1B;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_F = 8'h2B;
   localparam logic [7:0] SC_T = 8'h2C;
   localparam logic [7:0] SC_G = 8'h34;
   localparam logic [7:0] SC_Y = 8'h35;
   localparam logic [7:0] SC_H = 8'h33;
   localparam logic [7:0] SC_U = 8'h3C;
   localparam logic [7:0] SC_J = 8'h3B;
   localparam logic [7:0] SC_K = 8'h42;

   localparam int unsigned N_NOTAS = 13;
   localparam int unsigned TECLA_A = 0;
   localparam int unsigned TECLA_W = 1;
   localparam int unsigned TECLA_S = 2;
   localparam int unsigned TECLA_E = 3;
   localparam int unsigned TECLA_D = 4;
   localparam int unsigned TECLA_F = 5;
   localparam int unsigned TECLA_T = 6;
   localparam int unsigned TECLA_G = 7;
   localparam int unsigned TECLA_Y = 8;
   localparam int unsigned TECLA_H = 9;
   localparam int unsigned TECLA_U = 10;
   localparam int unsigned TECLA_J = 11;
   localparam int unsigned TECLA_K = 12;

   // One-hot note mask for a non-extended code; all zeros when the code is not a note key.
   function automatic logic [N_NOTAS-1:0] nota_mask(input logic [7:0] code);
      logic [N_NOTAS-1:0] m;
      m = '0;
      case (code)
         SC_A:    m[TECLA_A] = 1'b1;
         SC_W:    m[TECLA_W] = 1'b1;
         SC_S:    m[TECLA_S] = 1'b1;
         SC_E:    m[TECLA_E] = 1'b1;
         SC_D:    m[TECLA_D] = 1'b1;
         SC_F:    m[TECLA_F] = 1'b1;
         SC_T:    m[TECLA_T] = 1'b1;
         SC_G:    m[TECLA_G] = 1'b1;
         SC_Y:    m[TECLA_Y] = 1'b1;
         SC_H:    m[TECLA_H] = 1'b1;
         SC_U:    m[TECLA_U] = 1'b1;
         SC_J:    m[TECLA_J] = 1'b1;
         SC_K:    m[TECLA_K] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_receptor.sv
// PS/2 frame receiver: 2-flop sync, registered falling-edge detect, 11-bit frame FSM with timeout.
// Byte/error pulses one cycle after the stop-bit edge is detected; no backpressure (pulses are not held).
module ps2_receptor
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_byte_vld,
   output logic [7:0] o_byte,
   output logic       o_erro
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic          r_clk_s1, r_clk_s2, r_clk_d;
   logic          r_dat_s1, r_dat_s2;
   logic          r_fall, r_bit;
   logic [0:0]    r_estado;
   logic [3:0]    r_nbit;
   logic [8:0]    r_shift;
   logic [CW-1:0] r_cnt;
   logic          r_byte_vld, r_erro;
   logic [7:0]    r_byte;
   logic          w_timeout;

   assign w_timeout  = (r_estado == RECEBE) && (r_cnt == CW'(TIMEOUT_CYC - 1));
   assign o_byte_vld = r_byte_vld;
   assign o_byte     = r_byte;
   assign o_erro     = r_erro;

   // Data is registered alongside the edge flag so both describe the same pin sample.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_d  <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
         r_fall   <= 1'b0;
         r_bit    <= 1'b1;
      end else begin
         r_clk_s1 <= i_ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_clk_d  <= r_clk_s2;
         r_dat_s1 <= i_ps2_dat;
         r_dat_s2 <= r_dat_s1;
         r_fall   <= r_clk_d & ~r_clk_s2;
         r_bit    <= r_dat_s2;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_estado   <= OCIOSO;
         r_nbit     <= 4'd0;
         r_shift    <= 9'd0;
         r_cnt      <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= 8'd0;
         r_erro     <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_erro     <= 1'b0;
         if (r_estado == OCIOSO) begin
            r_cnt <= '0;
            if (r_fall) begin
               if (!r_bit) begin
                  r_estado <= RECEBE;
                  r_nbit   <= 4'd1;
               end else begin
                  r_erro <= 1'b1;
               end
            end
         end else if (r_fall) begin
            r_cnt  <= '0;
            r_nbit <= r_nbit + 4'd1;
            if (r_nbit == 4'd10) begin
               r_estado <= OCIOSO;
               // r_shift holds data[7:0] and parity in bit 8; odd parity means XOR of all nine is 1.
               if (r_bit && (^r_shift)) begin
                  r_byte_vld <= 1'b1;
                  r_byte     <= r_shift[7:0];
               end else begin
                  r_erro <= 1'b1;
               end
            end else begin
               r_shift <= {r_bit, r_shift[8:1]};
            end
         end else if (w_timeout) begin
            r_erro   <= 1'b1;
            r_estado <= OCIOSO;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_teclado_piano.sv
// PS/2 keyboard front end: decodes set-2 make/break codes into held key levels for the piano datapath.
// Key levels change two cycles after the stop-bit edge is detected; no backpressure, every byte is consumed.
module ps2_teclado_piano
   import ps2_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ       = 50_000_000,
   parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [12:0] teclas,
   output logic        right_arrow_pressed,
   output logic        left_arrow_pressed,
   output logic        enter_pressed,
   output logic        erro_frame,
   output logic [7:0]  db_scancode
);

   localparam int unsigned TIMEOUT_CYC = CLOCK_FREQ / 1_000_000 * FRAME_TIMEOUT_US;

   logic              w_byte_vld;
   logic [7:0]        w_byte;
   logic              w_erro;
   logic [N_NOTAS-1:0] w_mask;

   logic              r_ext, r_brk;
   logic [N_NOTAS-1:0] r_teclas;
   logic              r_direita, r_esquerda, r_enter;

   ps2_receptor #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_receptor (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_dat  (ps2_data),
      .o_byte_vld (w_byte_vld),
      .o_byte     (w_byte),
      .o_erro     (w_erro)
   );

   assign w_mask              = nota_mask(w_byte);
   assign teclas              = r_teclas;
   assign right_arrow_pressed = r_direita;
   assign left_arrow_pressed  = r_esquerda;
   assign enter_pressed       = r_enter;
   assign erro_frame          = w_erro;
   assign db_scancode         = w_byte;

   // Prefix bytes only arm flags; any other byte consumes them, mapped or not.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
         r_teclas   <= '0;
         r_direita  <= 1'b0;
         r_esquerda <= 1'b0;
         r_enter    <= 1'b0;
      end else if (w_byte_vld) begin
         if (w_byte == SC_EXT) begin
            r_ext <= 1'b1;
         end else if (w_byte == SC_BRK) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            if (!r_ext) begin
               r_teclas <= r_brk ? (r_teclas & ~w_mask) : (r_teclas | w_mask);
               if (w_byte == SC_ENTER) r_enter <= ~r_brk;
            end else begin
               if (w_byte == SC_DIREITA)  r_direita  <= ~r_brk;
               if (w_byte == SC_ESQUERDA) r_esquerda <= ~r_brk;
               if (w_byte == SC_ENTER)    r_enter    <= ~r_brk;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_teclado_piano.sv
// Self-checking bench for ps2_teclado_piano: directed vector table, hand-timed corner cases, random key traffic.
`timescale 1ns/1ps
module tb_ps2_teclado_piano;

   localparam int unsigned HALF = 10;
   localparam int unsigned TMO  = 200;

   logic        clock = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [12:0] teclas;
   logic        right_arrow_pressed;
   logic        left_arrow_pressed;
   logic        enter_pressed;
   logic        erro_frame;
   logic [7:0]  db_scancode;

   int n_checks   = 0;
   int n_errors   = 0;
   int err_pulses = 0;

   typedef struct {
      int          n;
      logic [23:0] bytes;
      logic [1:0]  bad;
      logic [15:0] exp_out;
      logic [7:0]  exp_scan;
      int          exp_err;
   } vec_t;

   vec_t        tbl [19];
   logic [15:0] w_out  [1:5];
   logic [7:0]  w_scan [1:5];
   logic        w_err  [1:5];
   logic [7:0]  key_code [17];
   logic        key_ext  [17];
   int          key_bit  [17];
   logic [7:0]  unm_code [9];

   ps2_teclado_piano #(
      .CLOCK_FREQ       (1_000_000),
      .FRAME_TIMEOUT_US (TMO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .ps2_clk             (ps2_clk),
      .ps2_data            (ps2_data),
      .teclas              (teclas),
      .right_arrow_pressed (right_arrow_pressed),
      .left_arrow_pressed  (left_arrow_pressed),
      .enter_pressed       (enter_pressed),
      .erro_frame          (erro_frame),
      .db_scancode         (db_scancode)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (erro_frame) err_pulses++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] outs();
      return {enter_pressed, left_arrow_pressed, right_arrow_pressed, teclas};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] code, input logic bad_par, input logic bad_stop,
                            input int first, input int last);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int b = first; b < last; b++) begin
         ps2_data = f[b];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
      send_bits(code, bad_par, bad_stop, 0, 11);
      repeat (30) @(negedge clock);
   endtask

   task automatic watch_stop(input logic [7:0] code, input logic bad_par);
      send_bits(code, bad_par, 1'b0, 0, 10);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clock);
         #1;
         w_out[i]  = outs();
         w_scan[i] = db_scancode;
         w_err[i]  = erro_frame;
      end
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clock);
   endtask

   initial begin
      int          e0, k, u, kind, exp_e;
      logic        pr;
      logic [7:0]  bb, last_scan;
      logic [15:0] model_out;

      // Expected results accumulate from one row to the next.
      tbl[0]  = '{1, 24'h00001C, 2'd0, 16'h0001, 8'h1C, 0};
      tbl[1]  = '{2, 24'h001CF0, 2'd0, 16'h0000, 8'h1C, 0};
      tbl[2]  = '{2, 24'h0074E0, 2'd0, 16'h2000, 8'h74, 0};
      tbl[3]  = '{3, 24'h74F0E0, 2'd0, 16'h0000, 8'h74, 0};
      tbl[4]  = '{2, 24'h005AE0, 2'd0, 16'h8000, 8'h5A, 0};
      tbl[5]  = '{3, 24'h5AF0E0, 2'd0, 16'h0000, 8'h5A, 0};
      tbl[6]  = '{1, 24'h00005A, 2'd0, 16'h8000, 8'h5A, 0};
      tbl[7]  = '{2, 24'h005AF0, 2'd0, 16'h0000, 8'h5A, 0};
      tbl[8]  = '{1, 24'h00001C, 2'd0, 16'h0001, 8'h1C, 0};
      tbl[9]  = '{1, 24'h000042, 2'd0, 16'h1001, 8'h42, 0};
      tbl[10] = '{1, 24'h000042, 2'd0, 16'h1001, 8'h42, 0};
      tbl[11] = '{2, 24'h001CF0, 2'd0, 16'h1000, 8'h1C, 0};
      tbl[12] = '{1, 24'h00001D, 2'd1, 16'h1000, 8'h1C, 1};
      tbl[13] = '{2, 24'h006BE0, 2'd0, 16'h5000, 8'h6B, 0};
      tbl[14] = '{2, 24'h001CE0, 2'd0, 16'h5000, 8'h1C, 0};
      tbl[15] = '{1, 24'h000074, 2'd0, 16'h5000, 8'h74, 0};
      tbl[16] = '{3, 24'h6BF0E0, 2'd0, 16'h1000, 8'h6B, 0};
      tbl[17] = '{2, 24'h0042F0, 2'd0, 16'h0000, 8'h42, 0};
      tbl[18] = '{1, 24'h00002B, 2'd2, 16'h0000, 8'h42, 1};

      key_code = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                   8'h33, 8'h3C, 8'h3B, 8'h42, 8'h5A, 8'h5A, 8'h74, 8'h6B};
      key_ext  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      key_bit  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15, 15, 13, 14};
      // First six are plain codes, last three are sent after E0.
      unm_code = '{8'h15, 8'h1A, 8'h76, 8'h29, 8'h74, 8'h6B, 8'h1C, 8'h75, 8'h72};

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_outs", outs(), 16'h0000);
      check("reset_scan", db_scancode, 8'h00);
      check("reset_err", erro_frame, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      for (int i = 0; i < 19; i++) begin
         e0 = err_pulses;
         for (int j = 0; j < tbl[i].n; j++) begin
            bb = tbl[i].bytes[j*8 +: 8];
            send_frame(bb, (j == tbl[i].n - 1) && (tbl[i].bad == 2'd1),
                           (j == tbl[i].n - 1) && (tbl[i].bad == 2'd2));
         end
         check($sformatf("vec%0d_out", i), outs(), tbl[i].exp_out);
         check($sformatf("vec%0d_scan", i), db_scancode, tbl[i].exp_scan);
         check($sformatf("vec%0d_err", i), err_pulses - e0, tbl[i].exp_err);
      end

      // Stop-bit edge timing: scancode one cycle after detection, key level one after that.
      watch_stop(8'h23, 1'b0);
      check("lat_scan_e3", w_scan[3], 8'h42);
      check("lat_scan_e4", w_scan[4], 8'h23);
      check("lat_out_e4", w_out[4], 16'h0000);
      check("lat_out_e5", w_out[5], 16'h0010);
      check("lat_err_e4", w_err[4], 1'b0);
      watch_stop(8'h24, 1'b1);
      check("perr_e3", w_err[3], 1'b0);
      check("perr_e4", w_err[4], 1'b1);
      check("perr_e5", w_err[5], 1'b0);
      check("perr_out", w_out[5], 16'h0010);
      check("perr_scan", w_scan[5], 8'h23);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0);
      check("rel_d_out", outs(), 16'h0000);

      // Falling edge with data high while idle is a start-bit error.
      e0 = err_pulses;
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clock);
      check("start_err_cnt", err_pulses - e0, 1);
      check("start_err_out", outs(), 16'h0000);

      e0 = err_pulses;
      send_bits(8'h1D, 1'b0, 1'b0, 0, 5);
      repeat (TMO + 50) @(negedge clock);
      check("tmo_err_cnt", err_pulses - e0, 1);
      send_frame(8'h1D, 1'b0, 1'b0);
      check("tmo_next_out", outs(), 16'h0002);
      check("tmo_next_scan", db_scancode, 8'h1D);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1D, 1'b0, 1'b0);
      check("tmo_rel_out", outs(), 16'h0000);

      send_frame(8'h1B, 1'b0, 1'b0);
      check("rst_pre_out", outs(), 16'h0004);
      send_bits(8'h1C, 1'b0, 1'b0, 0, 6);
      reset = 1'b1;
      #1;
      check("rst_mid_out", outs(), 16'h0000);
      check("rst_mid_scan", db_scancode, 8'h00);
      check("rst_mid_err", erro_frame, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      send_bits(8'h1C, 1'b0, 1'b0, 6, 11);
      repeat (TMO + 50) @(negedge clock);
      check("rst_tail_out", outs(), 16'h0000);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("rst_next_out", outs(), 16'h0001);
      check("rst_next_scan", db_scancode, 8'h1C);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);

      model_out = 16'h0000;
      last_scan = 8'h1C;
      for (int ev = 0; ev < 30; ev++) begin
         e0    = err_pulses;
         exp_e = 0;
         kind  = $urandom_range(0, 9);
         if (kind <= 5) begin
            k  = $urandom_range(0, 16);
            pr = 1'($urandom_range(0, 1));
            if (key_ext[k]) send_frame(8'hE0, 1'b0, 1'b0);
            if (!pr) send_frame(8'hF0, 1'b0, 1'b0);
            send_frame(key_code[k], 1'b0, 1'b0);
            model_out[key_bit[k]] = pr;
            last_scan = key_code[k];
         end else if (kind <= 7) begin
            u = $urandom_range(0, 8);
            if (u >= 6) send_frame(8'hE0, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 1'b0, 1'b0);
            send_frame(unm_code[u], 1'b0, 1'b0);
            last_scan = unm_code[u];
         end else if (kind == 8) begin
            bb = 8'($urandom_range(0, 255));
            send_frame(bb, 1'b1, 1'b0);
            exp_e = 1;
         end else begin
            send_frame(8'hE1, 1'b0, 1'b0);
            send_frame(8'h14, 1'b0, 1'b0);
            send_frame(8'h77, 1'b0, 1'b0);
            send_frame(8'hE1, 1'b0, 1'b0);
            send_frame(8'hF0, 1'b0, 1'b0);
            send_frame(8'h14, 1'b0, 1'b0);
            send_frame(8'hF0, 1'b0, 1'b0);
            send_frame(8'h77, 1'b0, 1'b0);
            last_scan = 8'h77;
         end
         check($sformatf("rnd%0d_out", ev), outs(), model_out);
         check($sformatf("rnd%0d_scan", ev), db_scancode, last_scan);
         check($sformatf("rnd%0d_err", ev), err_pulses - e0, exp_e);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
